// File: rtl/mem_stage_access_unit.sv
// Memory-stage access unit: one load/store per cycle against a data RAM
// or a load from an external buffer file, with a registered response.
module mem_stage_access_unit #(
  parameter int    DEPTH     = 1024,
  parameter int    NUM_BUF   = 2,
  parameter int    BUF_DEPTH = 32,
  parameter string INIT_FILE = "none.mem"
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  input  logic [1:0]                   req_size,
  input  logic                         req_signed,
  input  logic [2:0]                   req_buf_sel,
  input  logic                         stall,
  output logic [$clog2(BUF_DEPTH)-1:0] buf_rd_addr,
  input  logic [32*NUM_BUF-1:0]        buf_rd_data,
  output logic                         resp_valid,
  output logic [31:0]                  resp_rdata,
  output logic                         resp_err,
  output logic [7:0]                   err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_BUF
  } src_e;

  typedef struct packed {
    logic       valid;
    logic       err;
    src_e       src;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] lane;
  } resp_t;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ram_q;
  logic [31:0]   buf_q;
  resp_t         r_q;
  logic [7:0]    cnt_q;

  logic          accept;
  logic          in_range;
  logic          size_bad;
  logic          misalign;
  logic          bad_buf;
  logic          err;
  logic          we;
  logic          re;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   buf_word;
  src_e          src_d;

  assign req_ready   = !stall;
  assign accept      = req_valid & !stall;
  assign buf_rd_addr = req_addr[BW+1:2];
  assign idx         = req_addr[AW+1:2];
  assign in_range    = req_addr[31:2] < 30'(DEPTH);

  always_comb begin
    buf_word = '0;
    for (int k = 0; k < NUM_BUF; k++) begin
      if (req_buf_sel == 3'(k + 1)) begin
        buf_word = buf_rd_data[32*k +: 32];
      end
    end
  end

  always_comb begin
    be       = '0;
    wd       = req_wdata;
    size_bad = 1'b0;
    misalign = 1'b0;
    unique case (req_size)
      2'b00: begin
        be = 4'b0001 << req_addr[1:0];
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be       = req_addr[1] ? 4'b1100 : 4'b0011;
        wd       = {2{req_wdata[15:0]}};
        misalign = req_addr[0];
      end
      2'b10: begin
        be       = 4'b1111;
        misalign = |req_addr[1:0];
      end
      default: size_bad = 1'b1;
    endcase
  end

  assign bad_buf = (req_buf_sel > 3'(NUM_BUF))
                 | (req_write & (req_buf_sel != 3'd0));
  assign err = size_bad | misalign | bad_buf
             | ((req_buf_sel == 3'd0) & !in_range);

  // Reset gating drops a store whose edge arrives while reset is held.
  assign we = accept & req_write & !err & Reset;
  assign re = accept & !req_write & (req_buf_sel == 3'd0);

  always_comb begin
    src_d = SRC_NONE;
    if (!err && !req_write) begin
      src_d = (req_buf_sel == 3'd0) ? SRC_RAM : SRC_BUF;
    end
  end

  always_ff @(posedge Clk) begin
    if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wd[8*l +: 8];
      end
    end
    if (re) ram_q <= mem[idx];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_q   <= '0;
      buf_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      r_q.valid <= 1'b1;
      r_q.err   <= err;
      r_q.src   <= src_d;
      r_q.size  <= req_size;
      r_q.sgn   <= req_signed;
      r_q.lane  <= req_addr[1:0];
      buf_q     <= buf_word;
      if (err && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
    end else if (!stall) begin
      r_q.valid <= 1'b0;
      r_q.err   <= 1'b0;
      r_q.src   <= SRC_NONE;
    end
  end

  logic [31:0] raw;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        ld;

  // Extension is applied after the RAM output register.
  always_comb begin
    raw    = (r_q.src == SRC_BUF) ? buf_q : ram_q;
    byte_v = raw[{r_q.lane, 3'b000} +: 8];
    half_v = r_q.lane[1] ? raw[31:16] : raw[15:0];
    ld     = (r_q.src != SRC_NONE);
    resp_rdata = '0;
    unique case (1'b1)
      !ld: resp_rdata = '0;
      ld && r_q.size == 2'b00:
        resp_rdata = {{24{r_q.sgn & byte_v[7]}}, byte_v};
      ld && r_q.size == 2'b01:
        resp_rdata = {{16{r_q.sgn & half_v[15]}}, half_v};
      default: resp_rdata = raw;
    endcase
  end

  assign resp_valid = r_q.valid;
  assign resp_err   = r_q.err;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: directed table, corner sequences and
// randomized traffic against a byte-level reference model.
module tb_mem_stage_access_unit;

  localparam int DEPTH = 1024;
  localparam int NB    = 2;
  localparam int BUFD  = 32;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [2:0]  req_buf_sel = '0;
  logic        stall = 1'b0;
  logic [4:0]  buf_rd_addr;
  logic [32*NB-1:0] buf_rd_data;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  err_count;

  logic [31:0] bufw [NB];
  logic [7:0]  mb [int unsigned];

  int total = 0;
  int bad = 0;

  logic        ev;
  logic [31:0] ed;
  logic        ee;
  int          ec;

  mem_stage_access_unit #(
    .DEPTH(DEPTH), .NUM_BUF(NB), .BUF_DEPTH(BUFD),
    .INIT_FILE("none.mem")
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed), .req_buf_sel(req_buf_sel),
    .stall(stall), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .err_count(err_count)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    buf_rd_data = '0;
    for (int k = 0; k < NB; k++) buf_rd_data[32*k +: 32] = bufw[k];
  end

  typedef struct {
    logic        v;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic        sg;
    logic [2:0]  bs;
    logic        xv;
    logic [31:0] xd;
    logic        xe;
    logic [7:0]  xc;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] sz,
                     input logic sg, input logic [2:0] bs);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    req_size = sz; req_signed = sg; req_buf_sel = bs;
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  function automatic vec_t mk(logic v, logic w, logic [31:0] a,
      logic [31:0] d, logic [1:0] sz, logic sg, logic [2:0] bs,
      logic xv, logic [31:0] xd, logic xe, logic [7:0] xc);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.d = d; t.sz = sz; t.sg = sg;
    t.bs = bs; t.xv = xv; t.xd = xd; t.xe = xe; t.xc = xc;
    return t;
  endfunction

  task automatic model_req(input logic w, input logic [31:0] a,
      input logic [31:0] d, input logic [1:0] sz, input logic sg,
      input logic [2:0] bs, output logic e, output logic [31:0] r);
    int unsigned n;
    logic [7:0] b;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = (sz == 2'd3) || (a % n != 0) || (bs > NB)
      || (bs == 0 && (a / 4) >= DEPTH) || (w && bs != 0);
    r = '0;
    if (!e && w) begin
      for (int unsigned i = 0; i < n; i++) mb[a + i] = d[8*i +: 8];
    end
    if (!e && !w) begin
      for (int unsigned i = 0; i < n; i++) begin
        if (bs == 0) b = mb.exists(a + i) ? mb[a + i] : 8'h00;
        else b = bufw[bs - 1][8*((a % 4) + i) +: 8];
        r = r | (32'(b) << (8 * i));
      end
      if (sg && n < 4 && r[8*n - 1]) r = r | ~((32'h1 << (8 * n)) - 1);
    end
  endtask

  task automatic mstep();
    logic e;
    logic [31:0] r;
    #1;
    chk("ready", 32'(req_ready), 32'(!stall));
    chk("buf_rd_addr", 32'(buf_rd_addr), (req_addr >> 2) % BUFD);
    if (!stall) begin
      if (req_valid) begin
        model_req(req_write, req_addr, req_wdata, req_size,
                  req_signed, req_buf_sel, e, r);
        ev = 1'b1; ee = e; ed = r;
        if (e && ec < 255) ec++;
      end else begin
        ev = 1'b0; ee = 1'b0; ed = '0;
      end
    end
    cyc();
    chk("rnd_valid", 32'(resp_valid), 32'(ev));
    chk("rnd_rdata", resp_rdata, ed);
    chk("rnd_err", 32'(resp_err), 32'(ee));
    chk("rnd_count", 32'(err_count), 32'(ec));
  endtask

  initial begin
    bufw[0] = 32'hCAFEF00D;
    bufw[1] = 32'h12345678;

    tbl.push_back(mk(1,1,'h10,'hDEADBEEF,2,0,0, 1,'h0,0,0));
    tbl.push_back(mk(1,0,'h10,0,2,0,0, 1,'hDEADBEEF,0,0));
    tbl.push_back(mk(1,1,'h13,'h80,0,0,0, 1,'h0,0,0));
    tbl.push_back(mk(1,0,'h13,0,0,1,0, 1,'hFFFFFF80,0,0));
    tbl.push_back(mk(1,0,'h13,0,0,0,0, 1,'h00000080,0,0));
    tbl.push_back(mk(1,0,'h10,0,2,0,0, 1,'h80ADBEEF,0,0));
    tbl.push_back(mk(1,0,'h12,0,1,1,0, 1,'hFFFF80AD,0,0));
    tbl.push_back(mk(1,0,'h10,0,1,0,0, 1,'h0000BEEF,0,0));
    tbl.push_back(mk(1,0,'h11,0,1,0,0, 1,'h0,1,1));
    tbl.push_back(mk(1,1,'h0,'h0BADF00D,2,0,0, 1,'h0,0,1));
    tbl.push_back(mk(1,1,'h1000,'h55555555,2,0,0, 1,'h0,1,2));
    tbl.push_back(mk(1,0,'h0,0,2,0,0, 1,'h0BADF00D,0,2));
    tbl.push_back(mk(0,0,'h0,0,0,0,0, 0,'h0,0,2));
    tbl.push_back(mk(1,0,'h0C,0,2,0,2, 1,'h12345678,0,2));
    tbl.push_back(mk(1,0,'h01,0,0,1,1, 1,'hFFFFFFF0,0,2));
    tbl.push_back(mk(1,0,'h0E,0,1,0,2, 1,'h00001234,0,2));
    tbl.push_back(mk(1,0,'h0C,0,2,0,3, 1,'h0,1,3));
    tbl.push_back(mk(1,1,'h0C,'h1,2,0,1, 1,'h0,1,4));
    tbl.push_back(mk(1,0,'h0,0,3,0,0, 1,'h0,1,5));
    tbl.push_back(mk(1,0,'h12,0,2,0,0, 1,'h0,1,6));
    tbl.push_back(mk(1,0,'h1000,0,2,0,0, 1,'h0,1,7));
    tbl.push_back(mk(1,1,'hFFC,'h01020304,2,0,0, 1,'h0,0,7));
    tbl.push_back(mk(1,0,'hFFE,0,1,0,0, 1,'h00000102,0,7));
    tbl.push_back(mk(1,1,'hFFD,'hAB,0,0,0, 1,'h0,0,7));
    tbl.push_back(mk(1,0,'hFFC,0,2,0,0, 1,'h0102AB04,0,7));

    #12;
    chk("rst_valid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    chk("rst_count", 32'(err_count), 32'h0);
    cyc();
    Reset = 1'b1;

    foreach (tbl[i]) begin
      drv(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].sz,
          tbl[i].sg, tbl[i].bs);
      #1;
      chk($sformatf("t%0d_ready", i), 32'(req_ready), 32'h1);
      chk($sformatf("t%0d_bufaddr", i), 32'(buf_rd_addr),
          (tbl[i].a >> 2) % BUFD);
      cyc();
      chk($sformatf("t%0d_valid", i), 32'(resp_valid), 32'(tbl[i].xv));
      chk($sformatf("t%0d_rdata", i), resp_rdata, tbl[i].xd);
      chk($sformatf("t%0d_err", i), 32'(resp_err), 32'(tbl[i].xe));
      chk($sformatf("t%0d_count", i), 32'(err_count), 32'(tbl[i].xc));
    end

    drv(1, 1, 'h20, 'hA5A5A5A5, 2, 0, 0);
    cyc();
    drv(1, 0, 'h20, 0, 2, 0, 0);
    cyc();
    chk("b2b_rdata", resp_rdata, 32'hA5A5A5A5);
    drv(1, 1, 'h20, 'hFFFFFFFF, 2, 0, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", 32'(req_ready), 32'h0);
      cyc();
      chk("stall_valid", 32'(resp_valid), 32'h1);
      chk("stall_rdata", resp_rdata, 32'hA5A5A5A5);
      chk("stall_err", 32'(resp_err), 32'h0);
    end
    stall = 1'b0;
    drv(1, 0, 'h20, 0, 2, 0, 0);
    cyc();
    chk("stall_nowrite", resp_rdata, 32'hA5A5A5A5);
    chk("stall_count", 32'(err_count), 32'd7);

    drv(1, 0, 'h0, 0, 3, 0, 0);
    for (int i = 0; i < 260; i++) cyc();
    chk("sat_count", 32'(err_count), 32'd255);
    chk("sat_err", 32'(resp_err), 32'h1);
    cyc();
    chk("sat_hold", 32'(err_count), 32'd255);

    drv(1, 1, 'h40, 'h77777777, 2, 0, 0);
    cyc();
    drv(1, 1, 'h40, 'h11111111, 2, 0, 0);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_valid", 32'(resp_valid), 32'h0);
    chk("arst_rdata", resp_rdata, 32'h0);
    chk("arst_err", 32'(resp_err), 32'h0);
    chk("arst_count", 32'(err_count), 32'h0);
    cyc();
    chk("arst_hold", 32'(resp_valid), 32'h0);
    drv(1, 0, 'h40, 0, 2, 0, 0);
    Reset = 1'b1;
    cyc();
    chk("arst_drop", resp_rdata, 32'h77777777);
    chk("arst_cnt0", 32'(err_count), 32'h0);

    ev = 1'b1; ed = 32'h77777777; ee = 1'b0; ec = 0;
    for (int i = 0; i < 64; i++) begin
      drv(1, 1, 32'(4 * i), 0, 2, 0, 0);
      mstep();
    end
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 15);
      if (r < 13) a = $urandom_range(0, 255);
      else if (r < 15) a = 32'(4 * DEPTH) + $urandom_range(0, 255);
      else a = $urandom | 32'h0001_0000;
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      bufw[0] = $urandom;
      bufw[1] = $urandom;
      drv($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, a,
          $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0);
      stall = ($urandom_range(0, 7) == 0);
      mstep();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
